// File: rtl/intl_pkg.sv
// Shared constants for the interlock supervisor: state encoding, trip-count
// width/saturation and first-index width.
package intl_pkg;

    localparam logic [2:0] ST_DISABLED = 3'd0;
    localparam logic [2:0] ST_ARM      = 3'd1;
    localparam logic [2:0] ST_RUN      = 3'd2;
    localparam logic [2:0] ST_FAULT    = 3'd3;
    localparam logic [2:0] ST_CLEAR    = 3'd4;

    localparam int unsigned      CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_SAT = 16'hFFFF;
    localparam int unsigned      IDX_W   = 5;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_SAT) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/intl_prio_enc.sv
// Combinational lowest-set-bit encoder: reports the index of the lowest set
// bit of i_vec and whether any bit is set.
module intl_prio_enc
    import intl_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]     i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    always_comb begin
        // NOTE: outputs get a default before the loop so no path leaves them unassigned (no latch).
        o_idx   = '0;
        o_valid = 1'b0;
        // Scanning downwards lets the lowest set bit overwrite any higher one.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx   = IDX_W'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intl_ctrl.sv
// Interlock supervisor: arms detectors, trips shutdown on a masked flag, records
// the first tripping detector and re-arms after a verified clear. Optional
// feature macro: INTL_TIMESTAMP_EN adds o_fault_ts (cycle stamp of each capture).
module intl_ctrl
    import intl_pkg::*;
#(
    parameter int unsigned N_INTL  = 8,
    parameter int unsigned CLR_LEN = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [N_INTL-1:0] i_mask,
    input  logic [N_INTL-1:0] i_flag,
    input  logic              i_clr_req,
    input  logic [31:0]       i_arm_delay,
    output logic [N_INTL-1:0] o_intl_en,
    output logic              o_intl_clr,
    output logic              o_fault,
    output logic [N_INTL-1:0] o_fault_vec,
    output logic [IDX_W-1:0]  o_first_idx,
    output logic [CNT_W-1:0]  o_fault_cnt,
    output logic [2:0]        o_state
`ifdef INTL_TIMESTAMP_EN
    ,
    output logic [31:0]       o_fault_ts
`endif
);

    logic [2:0]        state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              clr_edge_q, clr_edge_d;
    logic [N_INTL-1:0] intl_en_q, intl_en_d;
    logic              intl_clr_q, intl_clr_d;
    logic              fault_q, fault_d;
    logic [N_INTL-1:0] fault_vec_q, fault_vec_d;
    logic [IDX_W-1:0]  first_idx_q, first_idx_d;
    logic [CNT_W-1:0]  fault_cnt_q, fault_cnt_d;

    logic [N_INTL-1:0] masked;
    logic [IDX_W-1:0]  prio_idx;
    logic              trip;
    logic              capture;

    assign masked = i_flag & i_mask;

    intl_prio_enc #(.N(N_INTL)) u_prio_enc (
        .i_vec   (masked),
        .o_idx   (prio_idx),
        .o_valid (trip)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fault_vec_d = fault_vec_q;
        first_idx_d = first_idx_q;
        fault_cnt_d = fault_cnt_q;
        capture     = 1'b0;
        req_d       = i_clr_req;
        // Edges are only armed while in FAULT, so a request held across the trip is ignored.
        clr_edge_d  = (state_q == ST_FAULT) && i_clr_req && !req_q;

        if (!i_en) begin
            state_d = ST_DISABLED;
        end else begin
            case (state_q)
                ST_DISABLED: begin
                    state_d = ST_ARM;
                    cnt_d   = '0;
                end
                ST_ARM: begin
                    if (cnt_q == i_arm_delay) state_d = ST_RUN;
                    else                      cnt_d   = cnt_q + 32'd1;
                end
                ST_RUN: begin
                    if (trip) begin
                        state_d = ST_FAULT;
                        capture = 1'b1;
                    end
                end
                ST_FAULT: begin
                    if (clr_edge_q) begin
                        state_d = ST_CLEAR;
                        cnt_d   = '0;
                    end
                end
                ST_CLEAR: begin
                    // One quiet cycle after the pulse lets the detectors drop their flags.
                    if (cnt_q == CLR_LEN) begin
                        if (trip) begin
                            state_d = ST_FAULT;
                            capture = 1'b1;
                        end else begin
                            state_d     = ST_ARM;
                            cnt_d       = '0;
                            fault_vec_d = '0;
                            first_idx_d = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                default: state_d = ST_DISABLED;
            endcase
        end

        if (capture) begin
            fault_vec_d = masked;
            first_idx_d = prio_idx;
            fault_cnt_d = sat_inc(fault_cnt_q);
        end

        intl_en_d  = (state_d == ST_ARM || state_d == ST_RUN ||
                      state_d == ST_FAULT || state_d == ST_CLEAR) ? i_mask : '0;
        intl_clr_d = (state_d == ST_CLEAR) && (cnt_d < CLR_LEN);
        fault_d    = (state_d == ST_FAULT) || (state_d == ST_CLEAR);
    end

    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking only; the reset is synchronous, so it is just the first branch under the edge.
        if (!i_rst) begin
            state_q     <= ST_DISABLED;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            clr_edge_q  <= 1'b0;
            intl_en_q   <= '0;
            intl_clr_q  <= 1'b0;
            fault_q     <= 1'b0;
            fault_vec_q <= '0;
            first_idx_q <= '0;
            fault_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            clr_edge_q  <= clr_edge_d;
            intl_en_q   <= intl_en_d;
            intl_clr_q  <= intl_clr_d;
            fault_q     <= fault_d;
            fault_vec_q <= fault_vec_d;
            first_idx_q <= first_idx_d;
            fault_cnt_q <= fault_cnt_d;
        end
    end

    assign o_intl_en   = intl_en_q;
    assign o_intl_clr  = intl_clr_q;
    assign o_fault     = fault_q;
    assign o_fault_vec = fault_vec_q;
    assign o_first_idx = first_idx_q;
    assign o_fault_cnt = fault_cnt_q;
    assign o_state     = state_q;

`ifdef INTL_TIMESTAMP_EN
    logic [31:0] ts_q, ts_d;
    logic [31:0] fault_ts_q, fault_ts_d;

    always_comb begin
        ts_d       = ts_q + 32'd1;
        fault_ts_d = capture ? ts_q : fault_ts_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            ts_q       <= '0;
            fault_ts_q <= '0;
        end else begin
            ts_q       <= ts_d;
            fault_ts_q <= fault_ts_d;
        end
    end

    assign o_fault_ts = fault_ts_q;
`endif

endmodule

// File: tb/tb_intl_ctrl.sv
// Self-checking bench for intl_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_intl_ctrl;

    localparam int N   = 8;
    localparam int CLR = 4;

    localparam logic [2:0] S_DIS = 3'd0;
    localparam logic [2:0] S_ARM = 3'd1;
    localparam logic [2:0] S_RUN = 3'd2;
    localparam logic [2:0] S_FLT = 3'd3;
    localparam logic [2:0] S_CLR = 3'd4;

    logic         clk = 1'b0;
    logic         rst, en, clr_req;
    logic [N-1:0] mask, flag;
    logic [31:0]  delay;

    logic [N-1:0] intl_en, fault_vec;
    logic         intl_clr, fault;
    logic [4:0]   first_idx;
    logic [15:0]  fault_cnt;
    logic [2:0]   state;
`ifdef INTL_TIMESTAMP_EN
    logic [31:0]  fault_ts;
    logic [31:0]  m_cyc = '0;
    logic [31:0]  m_ts  = '0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    intl_ctrl #(.N_INTL(N), .CLR_LEN(CLR)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_mask      (mask),
        .i_flag      (flag),
        .i_clr_req   (clr_req),
        .i_arm_delay (delay),
        .o_intl_en   (intl_en),
        .o_intl_clr  (intl_clr),
        .o_fault     (fault),
        .o_fault_vec (fault_vec),
        .o_first_idx (first_idx),
        .o_fault_cnt (fault_cnt),
        .o_state     (state)
`ifdef INTL_TIMESTAMP_EN
        ,
        .o_fault_ts  (fault_ts)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: state plus "cycles spent in the current state".
    logic [2:0]   m_state = S_DIS;
    int unsigned  m_age = 0;
    logic         m_prev_req = 1'b0, m_pending = 1'b0;
    logic [N-1:0] m_en = '0, m_vec = '0;
    logic         m_clr = 1'b0, m_fault = 1'b0;
    logic [4:0]   m_idx = '0;
    logic [15:0]  m_cnt = '0;
    logic         m_live = 1'b0;

    always @(posedge clk) begin : model_p
        logic [2:0]   ns;
        logic [N-1:0] masked, nvec;
        logic [4:0]   nidx;
        logic [15:0]  ncnt;
        int unsigned  nage;
        bit           cap;
        m_live <= 1'b1;
        if (!rst) begin
            m_state <= S_DIS; m_age <= 0; m_prev_req <= 1'b0; m_pending <= 1'b0;
            m_en <= '0; m_vec <= '0; m_clr <= 1'b0; m_fault <= 1'b0; m_idx <= '0; m_cnt <= '0;
`ifdef INTL_TIMESTAMP_EN
            m_cyc <= '0; m_ts <= '0;
`endif
        end else begin
            masked = flag & mask;
            ns = m_state; cap = 1'b0; nvec = m_vec; nidx = m_idx; ncnt = m_cnt;
            if (!en) ns = S_DIS;
            else begin
                case (m_state)
                    S_DIS: ns = S_ARM;
                    S_ARM: if (m_age == delay) ns = S_RUN;
                    S_RUN: if (masked != 0) begin ns = S_FLT; cap = 1'b1; end
                    S_FLT: if (m_pending) ns = S_CLR;
                    S_CLR: if (m_age == CLR) begin
                        if (masked != 0) begin ns = S_FLT; cap = 1'b1; end
                        else begin ns = S_ARM; nvec = '0; nidx = '0; end
                    end
                    default: ns = S_DIS;
                endcase
            end
            if (cap) begin
                nvec = masked;
                for (int i = 0; i < N; i++) if (masked[i]) begin nidx = 5'(i); break; end
                ncnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
            end
            nage = (ns == m_state) ? m_age + 1 : 0;
            m_state    <= ns;
            m_age      <= nage;
            m_vec      <= nvec;
            m_idx      <= nidx;
            m_cnt      <= ncnt;
            m_en       <= (ns != S_DIS) ? mask : '0;
            m_clr      <= (ns == S_CLR) && (nage < CLR);
            m_fault    <= (ns == S_FLT) || (ns == S_CLR);
            m_pending  <= (m_state == S_FLT) && clr_req && !m_prev_req;
            m_prev_req <= clr_req;
`ifdef INTL_TIMESTAMP_EN
            if (cap) m_ts <= m_cyc;
            m_cyc <= m_cyc + 32'd1;
`endif
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("state",     state,     m_state);
            check("intl_en",   intl_en,   m_en);
            check("intl_clr",  intl_clr,  m_clr);
            check("fault",     fault,     m_fault);
            check("fault_vec", fault_vec, m_vec);
            check("first_idx", first_idx, m_idx);
            check("fault_cnt", fault_cnt, m_cnt);
`ifdef INTL_TIMESTAMP_EN
            check("fault_ts",  fault_ts,  m_ts);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] s, input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (state !== s && n < max);
    endtask

    task automatic count_pulse(output int pulses);
        pulses = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (intl_clr === 1'b1) pulses++;
            else break;
        end
    endtask

    initial begin
        int n;
        rst = 1'b0; en = 1'b0; clr_req = 1'b0; mask = '1; flag = '0; delay = 32'd10;
        repeat (3) step();
        check("rst_state", state, 0);
        check("rst_cnt",   fault_cnt, 0);
        check("rst_en",    intl_en, 0);

        // Arm with a 10-cycle holdoff.
        rst = 1'b1; en = 1'b1;
        step();
        check("arm_entry", state, 1);
        check("arm_en",    intl_en, 8'hFF);
        wait_state(S_RUN, 50, n);
        check("arm_cycles", n, 11);

        // Single trip on two simultaneous flags.
        flag = 8'h24;
        step();
        flag = '0;
        check("trip_state", state, 3);
        check("trip_fault", fault, 1);
        check("trip_vec",   fault_vec, 8'h24);
        check("trip_idx",   first_idx, 2);
        check("trip_cnt",   fault_cnt, 1);

        // Successful clear: flags drop during the pulse.
        repeat (2) step();
        clr_req = 1'b1; flag = 8'h04;
        step();
        check("clr_edge_wait", state, 3);
        step();
        check("clr_entry", state, 4);
        check("clr_pulse", intl_clr, 1);
        clr_req = 1'b0; flag = '0;
        count_pulse(n);
        check("clr_len",   n, 4);
        check("clr_quiet", state, 4);
        step();
        check("clr_ok_state", state, 1);
        check("clr_ok_fault", fault, 0);
        check("clr_ok_vec",   fault_vec, 0);
        check("clr_ok_idx",   first_idx, 0);
        check("clr_ok_cnt",   fault_cnt, 1);

        // Masked-off flag never trips.
        wait_state(S_RUN, 50, n);
        mask = 8'hFE; flag = 8'h01;
        repeat (5) step();
        check("mask_state", state, 2);
        check("mask_en",    intl_en, 8'hFE);
        check("mask_fault", fault, 0);

        // Trip with an excluded bit, then a failed clear.
        flag = 8'h81;
        step();
        check("trip2_vec", fault_vec, 8'h80);
        check("trip2_idx", first_idx, 7);
        check("trip2_cnt", fault_cnt, 2);
        clr_req = 1'b1;
        repeat (2) step();
        check("fclr_entry", state, 4);
        clr_req = 1'b0;
        count_pulse(n);
        step();
        check("fclr_state", state, 3);
        check("fclr_idx",   first_idx, 7);
        check("fclr_vec",   fault_vec, 8'h80);
        check("fclr_cnt",   fault_cnt, 3);

        // Disable from FAULT keeps the captured record.
        en = 1'b0;
        step();
        check("dis_state", state, 0);
        check("dis_fault", fault, 0);
        check("dis_cnt",   fault_cnt, 3);
        check("dis_en",    intl_en, 0);
        check("dis_vec",   fault_vec, 8'h80);

        // Zero holdoff gives exactly one ARM cycle.
        en = 1'b1; flag = '0; mask = '1; delay = 32'd0;
        step();
        check("d0_arm", state, 1);
        step();
        check("d0_run", state, 2);

        // Reset mid-operation.
        flag = 8'h10;
        step();
        check("pre_rst_cnt", fault_cnt, 4);
        rst = 1'b0;
        step();
        check("rst2_state", state, 0);
        check("rst2_cnt",   fault_cnt, 0);
        check("rst2_vec",   fault_vec, 0);
        check("rst2_fault", fault, 0);
        check("rst2_en",    intl_en, 0);

        // Randomized traffic against the model.
        rst = 1'b1; flag = '0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) != 0);
            en  = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 5) == 0) clr_req = ~clr_req;
            if ($urandom_range(0, 9) == 0) mask = ($urandom_range(0, 1) == 1) ? '1 : N'($urandom);
            flag = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            if (m_state != S_ARM && $urandom_range(0, 7) == 0) delay = $urandom_range(0, 6);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
